// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, launch FSM states and the default baud divisor.
package uart_pkg;

  localparam int unsigned UART_DATA_W      = 8;
  localparam logic [15:0] UART_DEFAULT_DIV = 16'd650;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Launch handshake between the TX byte buffer and the UART transmitter.
interface uart_tx_fifo_if
  import uart_pkg::*;
();

  logic                   tx_start;
  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous show-ahead FIFO with a separate occupancy counter and a sticky overflow flag.
module sync_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned WIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              full_q;
  logic              empty_q;
  logic              overflow_q;
  logic              do_push;
  logic              do_pop;

  // Both qualifiers use the registered flags, so a push while full is dropped even alongside a pop.
  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      if (push && full_q) overflow_q <= 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_COUNT);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout     = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// TX byte buffer plus launch controller: queues bytes and hands them to the transmitter one at a time.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  output logic                   idle,
  uart_tx_fifo_if.master         tx
);

  tx_state_e              state_q;
  logic                   tx_start_q;
  logic [UART_DATA_W-1:0] tx_data_q;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   pop;

  assign pop = (state_q == IDLE) & ~empty & ~tx.tx_busy;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (UART_DATA_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_en),
    .pop      (pop),
    .din      (wr_data),
    .dout     (fifo_dout),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // Level handshake: tx_start stays high until the transmitter reports busy, however late that is.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= fifo_dout;
            tx_start_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: state_q <= WAIT_ACK;
        WAIT_ACK: begin
          if (tx.tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx.tx_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx.tx_start = tx_start_q;
  assign tx.tx_data  = tx_data_q;
  assign idle        = (state_q == IDLE) & empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: queue-based reference model plus a behavioural transmitter.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, idle;
  logic [4:0] count;
  logic       force_busy;
  logic       busy_m;

  uart_tx_fifo_if tx_if ();
  assign tx_if.tx_busy = busy_m | force_busy;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .idle     (idle),
    .tx       (tx_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0] q[$];
  logic       ovf_m;
  logic       in_flight, acked;
  logic [7:0] cur_byte;
  int         age;
  int         cycle = 0;
  int         launches = 0;
  int         last_launch_cycle = 0;
  logic       start_prev, busy_prev;

  // Transmitter model settings
  int ack_dly = 3;
  int hold    = 100;
  int ph, tcnt;

  logic       p_rst, p_wr, p_busy;
  logic [7:0] p_data;

  initial begin
    busy_m = 1'b0; ph = 0; tcnt = 0;
    ovf_m = 1'b0; in_flight = 1'b0; acked = 1'b0; cur_byte = 8'h00; age = 0;
    start_prev = 1'b0; busy_prev = 1'b0;
  end

  always begin : monitor
    logic launched, may_launch, must_launch, exp_start;
    int   cnt_pre;
    @(posedge clk);
    p_rst = reset; p_wr = wr_en; p_data = wr_data; p_busy = tx_if.tx_busy;
    #1;
    cycle++;
    if (p_rst) begin
      q.delete();
      ovf_m = 1'b0; in_flight = 1'b0; acked = 1'b0; age = 0;
      busy_m = 1'b0; ph = 0; tcnt = 0;
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_tx_start", 32'(tx_if.tx_start), 0);
      check("rst_tx_data", 32'(tx_if.tx_data), 0);
      check("rst_idle", 32'(idle), 1);
      start_prev = 1'b0;
      busy_prev  = 1'b0;
    end else begin
      cnt_pre     = q.size();
      may_launch  = !in_flight && cnt_pre > 0 && !p_busy;
      must_launch = may_launch && !busy_prev;
      if (p_wr) begin
        if (cnt_pre == DEPTH) ovf_m = 1'b1;
        else q.push_back(p_data);
      end
      launched = tx_if.tx_start && !start_prev;
      if (launched) begin
        check("launch_allowed", 32'(may_launch), 1);
        if (q.size() > 0) cur_byte = q.pop_front();
        check("launch_data", 32'(tx_if.tx_data), 32'(cur_byte));
        in_flight = 1'b1; acked = 1'b0; age = 0;
        launches++;
        last_launch_cycle = cycle;
      end else begin
        if (must_launch) check("launch_due", 32'(tx_if.tx_start), 1);
        if (in_flight) begin
          age++;
          if (!acked && age >= 2 && p_busy) acked = 1'b1;
          else if (acked && !p_busy) in_flight = 1'b0;
        end
      end
      exp_start = in_flight && !acked;
      check("tx_start", 32'(tx_if.tx_start), 32'(exp_start));
      if (in_flight) check("tx_data_hold", 32'(tx_if.tx_data), 32'(cur_byte));
      check("count", 32'(count), 32'(q.size()));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(ovf_m));
      check("idle", 32'(idle), 32'(!in_flight && q.size() == 0));
      start_prev = tx_if.tx_start;
      busy_prev  = p_busy;
      case (ph)
        0: if (tx_if.tx_start) begin tcnt = ack_dly; ph = 1; end
        1: begin
          tcnt--;
          if (tcnt <= 0) begin busy_m = 1'b1; tcnt = hold; ph = 2; end
        end
        default: begin
          tcnt--;
          if (tcnt <= 0) begin busy_m = 1'b0; ph = 0; end
        end
      endcase
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = b;
  endtask

  task automatic stop_push();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_launch(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (launches >= target) break;
      @(negedge clk);
    end
    check("launch_timeout", 32'(launches >= target), 1);
  endtask

  task automatic wait_drain(input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (idle && q.size() == 0 && !tx_if.tx_busy && ph == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_timeout", 32'(done), 1);
  endtask

  initial begin : stimulus
    int l0, push_cyc;
    logic found;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; force_busy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single byte, ack after 3 cycles, busy for 100
    ack_dly = 3; hold = 100;
    repeat (9) @(negedge clk);
    l0 = launches;
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    push_cyc = cycle;
    wait_launch(l0 + 1, 20);
    check("t1_latency", 32'(last_launch_cycle), 32'(push_cyc + 1));
    check("t1_data", 32'(tx_if.tx_data), 32'h A5);
    wait_drain(400);
    check("t1_launches", 32'(launches - l0), 1);

    // Burst of 16 bytes 00..0F
    ack_dly = 2; hold = 12;
    l0 = launches;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    stop_push();
    wait_drain(1500);
    check("t2_launches", 32'(launches - l0), 16);

    // 17 pushes with the transmitter held busy
    @(negedge clk);
    force_busy = 1'b1;
    l0 = launches;
    for (int i = 0; i < 17; i++) push_byte(8'($urandom));
    stop_push();
    check("t3_overflow", 32'(overflow), 1);
    check("t3_count", 32'(count), 16);
    check("t3_full", 32'(full), 1);
    repeat (5) @(negedge clk);
    check("t3_overflow_sticky", 32'(overflow), 1);
    force_busy = 1'b0;
    wait_drain(2000);
    check("t3_launches", 32'(launches - l0), 16);

    // Reset while in WAIT_DONE with 3 bytes queued
    ack_dly = 2; hold = 30;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    stop_push();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_if.tx_busy && q.size() == 3) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("t6_reach_wait_done", 32'(found), 1);
    @(negedge clk);
    check("t6_pre_reset_count", 32'(count), 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_count", 32'(count), 0);
    check("t6_empty", 32'(empty), 1);
    check("t6_tx_start", 32'(tx_if.tx_start), 0);
    check("t6_overflow", 32'(overflow), 0);
    l0 = launches;
    push_byte(8'h3C);
    stop_push();
    wait_drain(400);
    check("t6_launches", 32'(launches - l0), 1);

    // Push coincident with pop at count=5, then a 20-byte stream wrapping the pointers
    ack_dly = 1; hold = 2;
    @(negedge clk);
    force_busy = 1'b1;
    l0 = launches;
    for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i));
    @(negedge clk);
    force_busy = 1'b0;
    wr_data = 8'h45;
    @(negedge clk);
    wr_en = 1'b0;
    check("t4_count5", 32'(count), 5);
    for (int i = 6; i < 20; i++) begin
      repeat (3) @(negedge clk);
      push_byte(8'h40 + 8'(i));
      stop_push();
    end
    wait_drain(1000);
    check("t4_launches", 32'(launches - l0), 20);

    // Slow acknowledge: 40 cycles before busy rises
    ack_dly = 40; hold = 5;
    l0 = launches;
    push_byte(8'h11);
    push_byte(8'h22);
    stop_push();
    repeat (20) @(negedge clk);
    check("t5_start_held", 32'(tx_if.tx_start), 1);
    check("t5_no_second_pop", 32'(count), 1);
    wait_drain(500);
    check("t5_launches", 32'(launches - l0), 2);

    // Random traffic with varying transmitter timing
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        ack_dly = $urandom_range(1, 6);
        hold = $urandom_range(1, 10);
      end
    end
    stop_push();
    wait_drain(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and launch controller that sits directly upstream of the UART top level. It drives that block's tx_start/tx_data and watches its tx_busy.
- Software or upstream logic pushes bytes at any rate. The block queues them and starts one serial transmission at a time, back-to-back, with no lost or duplicated bytes.
- Uses a level handshake with the transmitter, so it stays correct regardless of how many cycles the transmitter takes to raise tx_busy.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, >= 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  push wr_data this cycle.
- wr_data  in  8  byte to enqueue.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  ADDR_W+1  bytes stored; excludes the byte currently being sent.
- overflow  out  1  sticky; set when a push is dropped.
- tx_start  out  1  launch request to the transmitter; level, held until acknowledged.
- tx_data  out  8  byte being launched; stable while tx_start=1 and while tx_busy=1.
- tx_busy  in  1  transmitter busy, from the UART top level.
- idle  out  1  FIFO empty and FSM in IDLE; all queued bytes fully sent.

Behaviour:
- Reset values:
  - count=0, empty=1, full=0, overflow=0.
  - tx_start=0, tx_data=8'h00, idle=1.
  - Read/write pointers = 0; FSM = IDLE.
- Reset mid-operation aborts everything:
  - Queued bytes are discarded and tx_start drops on the next edge.
  - The transmitter shares the same reset.
- Storage: DEPTH x 8 register array.
  - Pointers are ADDR_W bits and wrap modulo DEPTH.
  - count is tracked separately and gives full/empty. Registered outputs.
- Push:
  - wr_en=1 and full=0: write at wr_ptr; wr_ptr+1.
  - wr_en=1 and full=1: drop the byte; set overflow; pointers unchanged.
  - This holds even if a pop happens the same cycle, because full is evaluated on the registered count.
- Pop: happens only on the FSM transition IDLE->LAUNCH. The byte at rd_ptr is registered into tx_data; rd_ptr+1.
- Simultaneous push and pop with full=0: both take effect; count unchanged.
- FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
  - IDLE: if empty=0 and tx_busy=0, pop, set tx_start=1, go LAUNCH.
  - LAUNCH: always go WAIT_ACK; tx_start stays 1. This is one cycle of guaranteed assertion.
  - WAIT_ACK: when tx_busy=1, clear tx_start and go WAIT_DONE; otherwise hold tx_start=1.
  - WAIT_DONE: when tx_busy=0, go IDLE.
  - If tx_busy=1 while in IDLE (external activity), wait.
- Latency:
  - Push into an empty FIFO in IDLE at edge N gives count=1 after N.
  - The FSM pops at N+1, so tx_start=1 is visible after edge N+1.
  - Count returns to 0 on that same edge.
- Back-to-back: the next pop happens the cycle after the FSM returns to IDLE, giving at most 2 clocks of gap between tx_busy falling and the next tx_start rising.
- idle = (state==IDLE) & empty. It is combinational from registers.
- count width ADDR_W+1 covers 0..DEPTH inclusive; no arithmetic overflow.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W = 8.
  - FSM state encoding localparams: IDLE=2'd0, LAUNCH=2'd1, WAIT_ACK=2'd2, WAIT_DONE=2'd3.
  - Default divisor constant 16'd650 used by the UART top level.
- One natural sub-module, sync_fifo:
  - Parameterised DEPTH/ADDR_W/WIDTH.
  - Ports: push, pop, din, dout, full, empty, count, overflow.
- uart_tx_fifo = sync_fifo + launch FSM. sync_fifo is reusable later for an RX-side buffer.

Test Plan:
- Reset then single push 8'hA5 at cycle 10, transmitter model raises tx_busy 3 cycles after tx_start, holds it 100 cycles:
  - tx_start rises after cycle 11, falls the cycle after tx_busy rises.
  - tx_data=8'hA5 throughout.
  - idle=1 only after tx_busy falls.
- Burst push 16 bytes 8'h00..8'h0F in consecutive cycles:
  - full=1 after the 16th push unless a pop has already occurred; count never exceeds 16.
  - Transmitter receives 00..0F in order, each exactly once.
- Push 17 bytes with tx_busy forced 1 (no pops):
  - 17th dropped; overflow=1 and stays 1.
  - count=16; later drain yields only the first 16.
- Push on the same cycle as pop with count=5: count stays 5; pointers wrap correctly across a 20-byte stream (order checked).
- Slow ack: tx_busy rises 40 cycles after tx_start → tx_start held high all 40 cycles, tx_data stable, no second pop.
- Assert reset while in WAIT_DONE with count=3 → next cycle count=0, empty=1, tx_start=0, overflow=0, FSM IDLE; a subsequent push transmits normally.
